// File: rtl/uart_tx_engine_if.sv
// Handshake bundle between the tx FIFO/baud timer side and the UART transmit engine.
// master: FIFO-side driver (request, data, baud tick); slave: the transmit engine.
interface uart_tx_engine_if #(
  parameter int DATA_BITS = 8
);
  logic                 s_tick;
  logic                 tx_start;
  logic [DATA_BITS-1:0] din;
  logic                 tx_done_tick;
  logic                 tx_busy;
  logic                 tx;

  modport master (
    output s_tick,
    output tx_start,
    output din,
    input  tx_done_tick,
    input  tx_busy,
    input  tx
  );

  modport slave (
    input  s_tick,
    input  tx_start,
    input  din,
    output tx_done_tick,
    output tx_busy,
    output tx
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: start bit, DATA_BITS LSB-first, optional even parity, stop period.
// All timing advances only on the baud-timer s_tick. The tx line is a flop so it never glitches.
// Optional feature: define UART_TX_PARITY_EN to insert an even parity bit after the data bits
// (the receiver must be built with the same setting).
module uart_tx_engine #(
  parameter int DATA_BITS         = 8,
  parameter int TICKS_PER_DATABIT = 4,
  parameter int STOP_BIT_TICKS    = 4
) (
  input logic             clk,
  input logic             reset_n,
  uart_tx_engine_if.slave bus
);

  localparam int TICK_MAX = (TICKS_PER_DATABIT > STOP_BIT_TICKS) ? TICKS_PER_DATABIT : STOP_BIT_TICKS;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(TICKS_PER_DATABIT - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_BIT_TICKS - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state_reg, state_next;
  logic [TICK_W-1:0]    tick_reg, tick_next;
  logic [BIT_W-1:0]     bit_reg, bit_next;
  logic [DATA_BITS-1:0] shreg_reg, shreg_next;
  logic                 tx_reg, tx_next;
  logic                 done_reg, done_next;
`ifdef UART_TX_PARITY_EN
  // Parity of the word as latched; the shift register is consumed during DATA.
  logic                 parity_reg, parity_next;
`endif

  // State, counters, shift register and registered line/pulse outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      tick_reg   <= '0;
      bit_reg    <= '0;
      shreg_reg  <= '0;
      tx_reg     <= 1'b1;
      done_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      tick_reg   <= tick_next;
      bit_reg    <= bit_next;
      shreg_reg  <= shreg_next;
      tx_reg     <= tx_next;
      done_reg   <= done_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  // Next-state logic; the line level is derived from the next state so tx moves with the state.
  always_comb begin
    state_next  = state_reg;
    tick_next   = tick_reg;
    bit_next    = bit_reg;
    shreg_next  = shreg_reg;
    done_next   = 1'b0;
    tx_next     = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif

    case (state_reg)
      IDLE: begin
        // A tick in this cycle is deliberately not counted toward the start bit.
        if (bus.tx_start) begin
          state_next  = START;
          shreg_next  = bus.din;
          tick_next   = '0;
`ifdef UART_TX_PARITY_EN
          parity_next = ^bus.din;
`endif
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (tick_reg == BIT_LAST) begin
            tick_next  = '0;
            bit_next   = '0;
            state_next = DATA;
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (tick_reg == BIT_LAST) begin
            tick_next  = '0;
            shreg_next = shreg_reg >> 1;
            if (bit_reg == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              bit_next = bit_reg + 1'b1;
            end
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bus.s_tick) begin
          if (tick_reg == BIT_LAST) begin
            tick_next  = '0;
            state_next = STOP;
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (bus.s_tick) begin
          if (tick_reg == STOP_LAST) begin
            tick_next  = '0;
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = parity_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  assign bus.tx           = tx_reg;
  assign bus.tx_done_tick = done_reg;
  assign bus.tx_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Testbench for uart_tx_engine: a line decoder acts as the loopback receiver and checks each
// frame against a scoreboard of words queued when the request was driven.
module tb_uart_tx_engine;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB          = 9 + P;            // index of the stop bit in the frame
  localparam int FRAME_TICKS = NB * 4 + 4;       // (1+8+P)*4 + 4
  localparam int NV          = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } exp_t;

  typedef struct {
    logic [7:0] din;
    logic       exp_par;
  } vec_t;

  logic clk;
  logic reset_n;

  uart_tx_engine_if #(.DATA_BITS(8)) bus ();

  uart_tx_engine #(
    .DATA_BITS(8),
    .TICKS_PER_DATABIT(4),
    .STOP_BIT_TICKS(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  exp_t sb[$];
  vec_t vecs[NV];

  // monitor state
  logic        in_frame = 1'b0;
  logic        prev_tx = 1'b1;
  int          mon_tick = 0;
  logic [15:0] line_bits = '1;
  int          frames_done = 0;
  exp_t        mon_exp;
  int          tick_div = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout frames=%0d required_finish", frames_done);
    $fatal(1);
  end

  // baud tick: one pulse every 3 clocks
  initial begin
    bus.s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_div     = (tick_div == 2) ? 0 : tick_div + 1;
      bus.s_tick   = (tick_div == 2);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // line decoder / scoreboard consumer
  always @(negedge clk) begin
    if (!reset_n) begin
      if (in_frame && sb.size() > 0) mon_exp = sb.pop_front();
      in_frame = 1'b0;
      mon_tick = 0;
      prev_tx  = 1'b1;
    end else begin
      if (!in_frame && bus.tx_done_tick) begin
        checks++;
        errors++;
        $display("FAIL spurious_done actual=1 required=0");
      end
      if (!in_frame) begin
        if (prev_tx && !bus.tx) begin
          in_frame  = 1'b1;
          mon_tick  = bus.s_tick ? 1 : 0;
          line_bits = '1;
          check("busy_at_start", {31'b0, bus.tx_busy}, 1);
        end
      end else if (bus.tx_done_tick) begin
        frames_done++;
        check("frame_ticks", mon_tick, FRAME_TICKS);
        check("start_bit", {31'b0, line_bits[0]}, 0);
        check("stop_bit", {31'b0, line_bits[NB]}, 1);
        check("busy_end", {31'b0, bus.tx_busy}, 0);
        check("line_idle_end", {31'b0, bus.tx}, 1);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty actual_data=%02h required=queued_word", line_bits[8:1]);
        end else begin
          mon_exp = sb.pop_front();
          check("data", {24'b0, line_bits[8:1]}, {24'b0, mon_exp.data});
`ifdef UART_TX_PARITY_EN
          check("parity", {31'b0, line_bits[9]}, {31'b0, mon_exp.par});
`endif
        end
        $display("frame %0d data=%02h expected=%02h parity=%b ticks=%0d", frames_done,
                 line_bits[8:1], mon_exp.data, line_bits[9], mon_tick);
        in_frame = 1'b0;
      end else if (bus.s_tick) begin
        mon_tick++;
        if ((mon_tick % 4 == 2) && (mon_tick / 4 < 16)) line_bits[mon_tick / 4] = bus.tx;
      end
      prev_tx = bus.tx;
    end
  end

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (frames_done < target) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout actual=%0d required=%0d", frames_done, target);
    end
  endtask

  task automatic send_word(input logic [7:0] w, input logic par);
    int   target;
    exp_t e;
    target = frames_done + 1;
    @(posedge clk);
    #1;
    bus.din      = w;
    bus.tx_start = 1'b1;
    e.data = w;
    e.par  = par;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.tx_start = 1'b0;
    bus.din      = ~w;
    @(negedge clk);
    check("start_low", {31'b0, bus.tx}, 0);
    wait_frames(target, 400);
  endtask

  initial begin
    exp_t        e;
    int          n;
    int          target;
    int          done_before;
    logic [7:0]  w;

    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'h01, 1'b1};
    vecs[6] = '{8'h5A, 1'b0};
    vecs[7] = '{8'hFE, 1'b1};

    reset_n      = 1'b0;
    bus.tx_start = 1'b0;
    bus.din      = '0;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_tx", {31'b0, bus.tx}, 1);
    check("reset_busy", {31'b0, bus.tx_busy}, 0);
    check("reset_done", {31'b0, bus.tx_done_tick}, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // table of single frames
    for (int i = 0; i < NV; i++) send_word(vecs[i].din, vecs[i].exp_par);

    // back-to-back with tx_start held and din toggling mid-frame
    target = frames_done + 2;
    @(posedge clk);
    #1;
    bus.din      = 8'h3C;
    bus.tx_start = 1'b1;
    e.data = 8'h3C;
    e.par  = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.tx_done_tick) bus.din = 8'($urandom);
    end while (!bus.tx_done_tick && n < 400);
    if (!bus.tx_done_tick) begin
      checks++;
      errors++;
      $display("FAIL b2b_first_done actual=0 required=1");
    end
    bus.din = 8'hC3;
    e.data = 8'hC3;
    e.par  = 1'b0;
    sb.push_back(e);
    check("b2b_idle_clk", {31'b0, bus.tx}, 1);
    @(negedge clk);
    check("b2b_next_start", {31'b0, bus.tx}, 0);
    bus.tx_start = 1'b0;
    n = 0;
    while (frames_done < target && n < 400) begin
      @(negedge clk);
      n++;
      bus.din = 8'($urandom);
    end
    check("b2b_frames", frames_done, target);

    // reset during data bit 3
    @(posedge clk);
    #1;
    bus.din      = 8'h96;
    bus.tx_start = 1'b1;
    e.data = 8'h96;
    e.par  = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.tx_start = 1'b0;
    n = 0;
    while (mon_tick < 18 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("reached_bit3", {31'b0, (mon_tick >= 18)}, 1);
    @(posedge clk);
    #1;
    reset_n     = 1'b0;
    done_before = frames_done;
    @(posedge clk);
    @(negedge clk);
    check("midrst_tx", {31'b0, bus.tx}, 1);
    check("midrst_busy", {31'b0, bus.tx_busy}, 0);
    check("midrst_done", {31'b0, bus.tx_done_tick}, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    check("no_done_after_reset", frames_done, done_before);
    check("sb_after_abort", sb.size(), 0);
    send_word(8'h4B, 1'b0);

    // loopback of random words
    for (int i = 0; i < 6; i++) begin
      w = 8'($urandom);
      send_word(w, ^w);
    end

    repeat (10) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
